// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and frame constants for uart_tx_arbiter (UART_ARB_PARITY_EN adds the parity state)
package uart_arb_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

`ifdef UART_ARB_PARITY_EN
    localparam int PARITY_BITS = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;
`else
    localparam int PARITY_BITS = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;
`endif

    localparam int FRAME_BITS = 1 + DATA_BITS + PARITY_BITS + STOP_BITS;

endpackage

// File: rtl/bit_timer.sv
// rtl/bit_timer.sv - restartable bit-period counter, bit_done_out on the last cycle of each period
module bit_timer #(
    parameter int BAUD_DIV = 100
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic clear_in,
    output logic bit_done_out
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt <= '0;
        end else if (clear_in || cnt >= LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Deliberately not gated by clear_in: the FSM derives clear_in from bit_done_out.
    assign bit_done_out = (cnt >= LAST);

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter feeding an 8N1 serializer; UART_ARB_PARITY_EN adds even parity
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int BAUD_DIV = 100
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [NUM_REQ-1:0]         req_valid_in,
    input  logic [NUM_REQ*8-1:0]       req_data_in,
    output logic [NUM_REQ-1:0]         req_ready_out,
    output logic                       tx_out,
    output logic                       busy_out,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_out
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int BIW = $clog2(DATA_BITS);

    state_t             state, state_nx;
    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     winner;
    logic [7:0]         win_data;
    logic               found;
    logic               hs;
    int                 arb_idx;
    logic [7:0]         shreg, shreg_nx;
    logic [BIW-1:0]     bit_idx, bit_idx_nx;
    logic               bit_done;
    logic               tmr_clear;
    logic               tx_nx;
    logic               par_bit;

    // Search starts at rr_ptr and wraps, so the last winner has lowest priority next time.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        win_data = '0;
        arb_idx  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            arb_idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!found && req_valid_in[arb_idx]) begin
                found    = 1'b1;
                winner   = IDW'(arb_idx);
                win_data = req_data_in[8*arb_idx +: 8];
            end
        end
    end

    assign hs            = found && (state == ST_IDLE);
    assign req_ready_out = (hs && rst_in) ? (NUM_REQ'(1) << winner) : '0;

    bit_timer #(
        .BAUD_DIV     (BAUD_DIV)
    ) u_bit_timer (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .clear_in     (tmr_clear),
        .bit_done_out (bit_done)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (hs) state_nx = ST_START;
            ST_START:  if (bit_done) state_nx = ST_DATA;
            ST_DATA: begin
                if (bit_done && bit_idx == BIW'(DATA_BITS - 1)) begin
`ifdef UART_ARB_PARITY_EN
                    state_nx = ST_PARITY;
`else
                    state_nx = ST_STOP;
`endif
                end
            end
`ifdef UART_ARB_PARITY_EN
            ST_PARITY: if (bit_done) state_nx = ST_STOP;
`endif
            ST_STOP: begin
                if (bit_done && bit_idx == BIW'(STOP_BITS - 1)) state_nx = ST_IDLE;
            end
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Any state change restarts the bit period, so every bit lasts exactly BAUD_DIV cycles.
    assign tmr_clear = (state_nx != state) || (state == ST_IDLE);

    always_comb begin
        shreg_nx = shreg;
        if (hs) begin
            shreg_nx = win_data;
        end else if (state == ST_DATA && bit_done) begin
            shreg_nx = {1'b0, shreg[7:1]};
        end

        bit_idx_nx = bit_idx;
        if (state_nx != state) begin
            bit_idx_nx = '0;
        end else if (bit_done) begin
            bit_idx_nx = bit_idx + 1'b1;
        end

        // tx_out is registered, so it is driven from the state being entered.
        tx_nx = 1'b1;
        case (state_nx)
            ST_START:  tx_nx = 1'b0;
            ST_DATA:   tx_nx = shreg_nx[0];
`ifdef UART_ARB_PARITY_EN
            ST_PARITY: tx_nx = par_bit;
`endif
            default:   tx_nx = 1'b1;
        endcase
    end

`ifdef UART_ARB_PARITY_EN
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            par_bit <= 1'b0;
        end else if (hs) begin
            par_bit <= ^win_data;
        end
    end
`else
    assign par_bit = 1'b0;
`endif

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            shreg        <= '0;
            bit_idx      <= '0;
            rr_ptr       <= '0;
            grant_id_out <= '0;
            tx_out       <= 1'b1;
            busy_out     <= 1'b0;
        end else begin
            shreg    <= shreg_nx;
            bit_idx  <= bit_idx_nx;
            tx_out   <= tx_nx;
            busy_out <= (state_nx != ST_IDLE);
            if (hs) begin
                grant_id_out <= winner;
                rr_ptr       <= (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + IDW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter (NUM_REQ=4, BAUD_DIV=4)
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int BD = 4;
`ifdef UART_ARB_PARITY_EN
    localparam int TB_BITS = 11;
`else
    localparam int TB_BITS = 10;
`endif
    localparam int FRAME_CYC = TB_BITS * BD;

    logic            clk_in = 1'b0;
    logic            rst_in = 1'b0;
    logic [NR-1:0]   req_valid_in = '0;
    logic [NR*8-1:0] req_data_in = '0;
    logic [NR-1:0]   req_ready_out;
    logic            tx_out;
    logic            busy_out;
    logic [1:0]      grant_id_out;

    always #5 clk_in = ~clk_in;

    uart_tx_arbiter #(
        .NUM_REQ       (NR),
        .BAUD_DIV      (BD)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .req_valid_in  (req_valid_in),
        .req_data_in   (req_data_in),
        .req_ready_out (req_ready_out),
        .tx_out        (tx_out),
        .busy_out      (busy_out),
        .grant_id_out  (grant_id_out)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h need 0x%0h", name, act, exp);
        end
    endtask

    // Line image of one frame, bit 0 = start bit; unused upper bits stay 1.
    function automatic logic [10:0] model(input logic [7:0] b);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef UART_ARB_PARITY_EN
        f[9]   = ^b;
`endif
        return f;
    endfunction

    int          exp_gnt[$];
    logic [10:0] exp_frm[$];

    int          gnt_rd = 0;
    int          frm_rd = 0;
    int          hs_total = 0;
    int          hs_last = 0;
    int          hs_cyc[64];
    int          cyc = 0;
    int          rdy_cnt[NR];
    bit          fr_active = 0;
    int          fr_cyc = 0;
    logic [10:0] fr_bits;
    logic [10:0] fr_exp;
    logic        cur;
    bit          stable;
    int          busy_run = 0;
    bit          gid_chk = 0;
    int          gid_exp = 0;

    initial begin
        for (int i = 0; i < NR; i++) rdy_cnt[i] = 0;
        forever begin : mon
            int idx;
            @(negedge clk_in);
            cyc++;
            for (int i = 0; i < NR; i++) rdy_cnt[i] += int'(req_ready_out[i]);
            if (gid_chk) begin
                gid_chk = 0;
                if (rst_in) check("grant_id", longint'(grant_id_out), gid_exp);
            end
            if (!rst_in) begin
                fr_active = 0;
                busy_run  = 0;
            end else begin
                if (req_ready_out != 0) begin
                    check("ready_onehot", longint'($onehot(req_ready_out)), 1);
                    check("ready_without_valid", longint'(req_ready_out & ~req_valid_in), 0);
                end
                if ((req_ready_out & req_valid_in) != 0) begin
                    idx = -1;
                    for (int i = 0; i < NR; i++)
                        if (idx < 0 && req_ready_out[i] && req_valid_in[i]) idx = i;
                    if (gnt_rd < exp_gnt.size()) begin
                        check("grant", idx, exp_gnt[gnt_rd]);
                        gnt_rd++;
                    end else begin
                        check("unexpected_grant", idx, -1);
                    end
                    hs_cyc[hs_total % 64] = cyc;
                    hs_last = idx;
                    hs_total++;
                    gid_chk = 1;
                    gid_exp = idx;
                end
                if (busy_out) begin
                    busy_run++;
                end else if (busy_run != 0) begin
                    check("busy_len", busy_run, FRAME_CYC);
                    busy_run = 0;
                end
                if (!fr_active && tx_out == 1'b0) begin
                    fr_active = 1;
                    fr_cyc    = 0;
                    fr_bits   = '1;
                    stable    = 1;
                    fr_exp    = '1;
                    if (frm_rd < exp_frm.size()) begin
                        fr_exp = exp_frm[frm_rd];
                        frm_rd++;
                    end else begin
                        check("unexpected_frame", frm_rd, exp_frm.size());
                    end
                end
                if (fr_active) begin
                    if (fr_cyc % BD == 0) cur = tx_out;
                    else if (tx_out !== cur) stable = 0;
                    if (fr_cyc % BD == BD - 1) fr_bits[fr_cyc / BD] = cur;
                    fr_cyc++;
                    if (fr_cyc == FRAME_CYC) begin
                        check("frame", longint'(fr_bits), longint'(fr_exp));
                        check("bit_stable", longint'(stable), 1);
                        fr_active = 0;
                    end
                end
            end
        end
    end

    int req_cnt[NR];
    int hs_done = 0;

    task automatic apply_valid();
        for (int i = 0; i < NR; i++) req_valid_in[i] = (req_cnt[i] != 0);
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
        if (hs_done != hs_total) begin
            if (req_cnt[hs_last] > 0) req_cnt[hs_last]--;
            hs_done = hs_total;
        end
        apply_valid();
    endtask

    task automatic set_req(input int id, input logic [7:0] b, input int n);
        req_data_in[8*id +: 8] = b;
        req_cnt[id] = n;
    endtask

    task automatic expect_tx(input int id, input logic [7:0] b);
        exp_gnt.push_back(id);
        exp_frm.push_back(model(b));
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        for (int i = 0; i < NR; i++) req_cnt[i] = 0;
        apply_valid();
        step();
        step();
    endtask

    task automatic release_reset();
        apply_valid();
        rst_in = 1'b1;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit ok;
        bit idle;
        ok = 0;
        for (int n = 0; n < budget; n++) begin
            step();
            idle = !busy_out && !fr_active && (hs_done == hs_total);
            for (int i = 0; i < NR; i++) if (req_cnt[i] != 0) idle = 0;
            if (idle) begin
                ok = 1;
                break;
            end
        end
        check({name, "_finished"}, ok, 1);
        check({name, "_grants_seen"}, gnt_rd, exp_gnt.size());
        check({name, "_frames_seen"}, frm_rd, exp_frm.size());
    endtask

    initial begin
        int r0[NR];
        int base;
        for (int i = 0; i < NR; i++) req_cnt[i] = 0;

        // reset state
        do_reset();
        check("rst_tx", longint'(tx_out), 1);
        check("rst_busy", longint'(busy_out), 0);
        check("rst_ready", longint'(req_ready_out), 0);
        check("rst_grant_id", longint'(grant_id_out), 0);

        // 1: single request, 0xA5 from req 0
        r0 = rdy_cnt;
        set_req(0, 8'hA5, 1);
        expect_tx(0, 8'hA5);
        release_reset();
        wait_done("single", 200);
        check("single_ready0_cycles", rdy_cnt[0] - r0[0], 1);
        check("single_ready_other", (rdy_cnt[1] - r0[1]) + (rdy_cnt[2] - r0[2]) + (rdy_cnt[3] - r0[3]), 0);

        // 2: all four contend from reset
        do_reset();
        for (int i = 0; i < NR; i++) begin
            set_req(i, 8'(8'h10 + i), 1);
            expect_tx(i, 8'(8'h10 + i));
        end
        base = hs_total;
        release_reset();
        wait_done("contend", 800);
        for (int k = 0; k < 3; k++)
            check("contend_hs_spacing", hs_cyc[(base + k + 1) % 64] - hs_cyc[(base + k) % 64], FRAME_CYC + 1);

        // 3: wrap-around with reqs 0 and 2 held valid
        do_reset();
        r0 = rdy_cnt;
        set_req(0, 8'h5A, 2);
        set_req(2, 8'hC3, 2);
        expect_tx(0, 8'h5A);
        expect_tx(2, 8'hC3);
        expect_tx(0, 8'h5A);
        expect_tx(2, 8'hC3);
        release_reset();
        wait_done("wrap", 800);
        check("wrap_ready1_cycles", rdy_cnt[1] - r0[1], 0);
        check("wrap_ready3_cycles", rdy_cnt[3] - r0[3], 0);

        // 4: reset during data bit 3, then req 1 sends a full frame
        do_reset();
        set_req(0, 8'h3C, 1);
        expect_tx(0, 8'h3C);
        release_reset();
        base = hs_total;
        for (int n = 0; n < 20 && hs_done == base; n++) step();
        check("midrst_first_hs", hs_done - base, 1);
        for (int n = 0; n < 17; n++) step();
        set_req(1, 8'h81, 1);
        rst_in = 1'b0;
        #1;
        check("midrst_tx", longint'(tx_out), 1);
        check("midrst_busy", longint'(busy_out), 0);
        check("midrst_ready", longint'(req_ready_out), 0);
        step();
        expect_tx(1, 8'h81);
        release_reset();
        wait_done("midrst", 200);

`ifdef UART_ARB_PARITY_EN
        // 5: parity frame for 0x07 from req 3
        do_reset();
        set_req(3, 8'h07, 1);
        expect_tx(3, 8'h07);
        release_reset();
        wait_done("parity", 200);
        check("parity_bit_of_07", longint'(model(8'h07) >> 9) & 1, 1);
`endif

        // 6: back-to-back frames from req 0
        do_reset();
        set_req(0, 8'h96, 2);
        expect_tx(0, 8'h96);
        expect_tx(0, 8'h96);
        base = hs_total;
        release_reset();
        wait_done("b2b", 400);
        check("b2b_hs_spacing", hs_cyc[(base + 1) % 64] - hs_cyc[base % 64], FRAME_CYC + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmit line among `NUM_REQ` byte producers using round-robin arbitration. It also serializes the granted byte as an 8N1 frame, with optional even parity.
- Bit pacing comes from an internal restartable bit-period counter, clocked on the system clock.
- The block sits between the design's message sources (chat, status, debug) and the board TX pin.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters; must be ≥ 2.
- `BAUD_DIV`, default 100: system-clock cycles per serial bit; must be ≥ 2.

Ports:
- `clk_in`, input, 1: system clock.
- `rst_in`, input, 1: asynchronous, active-low reset.
- `req_valid_in`, input, `NUM_REQ`: requester i has a byte pending.
- `req_data_in`, input, `NUM_REQ*8`: byte of requester i is at bits `[8i+7:8i]`.
- `req_ready_out`, output, `NUM_REQ`: one-hot accept strobe.
- `tx_out`, output, 1: serial line; idles high.
- `busy_out`, output, 1: a frame is in flight.
- `grant_id_out`, output, `$clog2(NUM_REQ)`: index of the last accepted requester.

## Operation
- States: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- **Arbitration (IDLE only):**
  - The winner is the first i with `req_valid_in[i]`, searching from `rr_ptr` upward and wrapping modulo `NUM_REQ`.
  - `req_ready_out` is combinational: the one-hot winner while in IDLE and out of reset, zero otherwise.
  - A handshake occurs when valid and ready are both high at a clock edge.
  - On a handshake: latch the byte into the shift register, set `grant_id_out` to the winner, set `rr_ptr` to winner+1 (mod `NUM_REQ`), and go to START.
- **Requester rules:** a requester must not make valid depend on ready. Dropping valid before a handshake is legal and has no effect.
- **Bit order:** START drives 0. DATA drives 8 bits, LSB first. STOP drives 1.
- **Bit-period counter:**
  - Counts 0..`BAUD_DIV`-1 and is cleared at every state entry, so every bit is exactly `BAUD_DIV` cycles.
  - The bit index counts 0..7 in DATA.
  - Width is `$clog2(BAUD_DIV)`, saturating compare at `BAUD_DIV`-1.
- **Frame end:** after STOP completes, return to IDLE. A requester still holding valid competes again with no priority.
- **Reset values (applied immediately on `rst_in` low, even mid-frame):**
  - state IDLE, `tx_out`=1, `busy_out`=0, `req_ready_out`=0, `grant_id_out`=0, `rr_ptr`=0.
  - Shift register, bit-period counter and bit index are cleared.
  - The interrupted frame is abandoned; no partial handshake is recorded.

## Timing
- Handshake in cycle T. All cycle references below are relative to T.
- `tx_out` and `busy_out` are registered outputs.
- Start bit on `tx_out`: cycles T+1..T+`BAUD_DIV`.
- Data bit k: cycles T+1+(k+1)·`BAUD_DIV` .. T+(k+2)·`BAUD_DIV`.
- Stop bit: cycles T+1+9·`BAUD_DIV` .. T+10·`BAUD_DIV`.
- `busy_out` is high for cycles T+1..T+10·`BAUD_DIV`.
- The next handshake is possible at T+10·`BAUD_DIV`+1. Back-to-back frames therefore show a stop level of `BAUD_DIV`+1 cycles.
- With parity: the parity bit is inserted before the stop bit, and all frame-end figures use 11·`BAUD_DIV`.

## Configuration
- Macro: `UART_ARB_PARITY_EN`.
- **Defined:** PARITY state is compiled in and drives the even-parity bit, i.e. the XOR of the 8 data bits, for one bit period. Frame is 11 bits.
- **Undefined:** PARITY state and its logic are absent. Frame is 10 bits (8N1).

## Structure
- Package `uart_arb_pkg` holds:
  - the state enum typedef;
  - `DATA_BITS` = 8;
  - `STOP_BITS` = 1;
  - the frame-length localparam, derived from the macro.
- Sub-module `bit_timer`: restartable `BAUD_DIV` counter with `clear_in`, emitting `bit_done_out` on count `BAUD_DIV`-1. The FSM, arbiter and shifter stay in the top.

## Test plan
All scenarios use `NUM_REQ`=4 and `BAUD_DIV`=4.
1. **Single request:** req 0 sends 0xA5.
   - `req_ready_out`=0001 for 1 cycle.
   - `tx_out` in 4-cycle bits: 0,1,0,1,0,0,1,0,1,1.
   - `busy_out` high for 40 cycles; `grant_id_out`=0.
2. **All requesters contend:** all four valid from reset with bytes 0x10..0x13.
   - Grants go 0,1,2,3, handshakes 41 cycles apart.
   - The byte order on the line matches.
3. **Wrap-around:** reqs 0 and 2 held valid.
   - Grants go 0,2,0,2, showing the pointer wraps past 3.
   - Req 1 and req 3 ready never assert.
4. **Reset mid-frame:** `rst_in` pulled low during data bit 3.
   - `tx_out`=1, `busy_out`=0, `req_ready_out`=0 in the same cycle.
   - After release, with req 1 valid: req 1 is granted and its full frame is sent.
5. **Parity** (`UART_ARB_PARITY_EN` defined): byte 0x07.
   - Parity bit = 1; frame is 11 bits.
   - `busy_out` high for 44 cycles.
6. **Back-to-back:** req 0 held valid continuously.
   - Second handshake at T+41.
   - `tx_out` high for cycles T+37..T+41; start bit at T+42.
